// File: rtl/fifo_pkg.sv
// Shared constants and the pointer/level width helper for the skid-margin FIFO.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_FIFO_DEPTH   = 32;
  localparam int DEF_FIFO_SKID    = 4;
  localparam int DEF_AFULL_MARGIN = 8;

  // One extra bit so a full RAM is distinguishable from an empty one.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port storage: one write port, one synchronous read port.
module sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fifo_skid_v2.sv
// FWFT FIFO with skid-margin ready, sticky overflow and synchronous flush.
// The RAM read register holds the head word; head validity is tracked here.
module fifo_skid_v2 import fifo_pkg::*; #(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int FIFO_SKID   = DEF_FIFO_SKID,
  parameter int AFULL_LEVEL = FIFO_DEPTH - DEF_AFULL_MARGIN
) (
  input  logic                        clkIn,
  input  logic                        rstNIn,
  input  logic [DATA_WIDTH-1:0]       wrDataIn,
  input  logic                        wrValidIn,
  output logic                        wrReadyOut,
  output logic [DATA_WIDTH-1:0]       rdDataOut,
  output logic                        rdValidOut,
  input  logic                        rdReadyIn,
  input  logic                        flushIn,
  output logic [$clog2(FIFO_DEPTH):0] levelOut,
  output logic                        almostFullOut,
  output logic                        overflowOut
);
  localparam int LW = lvl_width(FIFO_DEPTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] SKID_L  = LW'(FIFO_SKID);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LEVEL);

  logic [LW-1:0] wr_ptr, rd_ptr, ram_cnt, level_nxt;
  logic          rd_fire, wr_fire, wr_drop, fetch;

  // ram_cnt counts words still in RAM, i.e. not yet loaded into the head.
  assign ram_cnt = wr_ptr - rd_ptr;
  assign rd_fire = rdValidOut & rdReadyIn;
  assign wr_fire = wrValidIn & ~flushIn & (levelOut < DEPTH_L);
  assign wr_drop = wrValidIn & ~flushIn & (levelOut == DEPTH_L);
  assign fetch   = ~flushIn & (ram_cnt != '0) & (~rdValidOut | rdReadyIn);

  always_comb begin
    level_nxt = levelOut;
    if (flushIn)                level_nxt = '0;
    else if (wr_fire & ~rd_fire) level_nxt = levelOut + 1'b1;
    else if (~wr_fire & rd_fire) level_nxt = levelOut - 1'b1;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      levelOut      <= '0;
      rdValidOut    <= 1'b0;
      wrReadyOut    <= 1'b0;
      almostFullOut <= 1'b0;
      overflowOut   <= 1'b0;
    end else begin
      if (flushIn) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        rdValidOut  <= 1'b0;
        overflowOut <= 1'b0;
      end else begin
        if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
        if (fetch)   rd_ptr <= rd_ptr + 1'b1;
        rdValidOut <= fetch | (rdValidOut & ~rdReadyIn);
        if (wr_drop) overflowOut <= 1'b1;
      end
      levelOut      <= level_nxt;
      wrReadyOut    <= (DEPTH_L - level_nxt) > SKID_L;
      almostFullOut <= level_nxt >= AFULL_L;
    end
  end

  sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_ram (
    .clk    (clkIn),
    .wr_en  (wr_fire),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_data(wrDataIn),
    .rd_en  (fetch),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_data(rdDataOut)
  );
endmodule

// File: tb/tb_fifo_skid_v2.sv
// Scoreboard bench: a timestamped word-queue model drives level/flag expectations,
// and a negedge monitor pops expected data on every DUT read handshake.
module tb_fifo_skid_v2;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int SKID  = 4;
  localparam int AFULL = DEPTH - 8;

  logic          clkIn, rstNIn;
  logic [DW-1:0] wrDataIn, rdDataOut;
  logic          wrValidIn, wrReadyOut, rdValidOut, rdReadyIn, flushIn;
  logic [$clog2(DEPTH):0] levelOut;
  logic          almostFullOut, overflowOut;

  fifo_skid_v2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FIFO_SKID(SKID), .AFULL_LEVEL(AFULL)) dut (
    .clkIn(clkIn), .rstNIn(rstNIn), .wrDataIn(wrDataIn), .wrValidIn(wrValidIn),
    .wrReadyOut(wrReadyOut), .rdDataOut(rdDataOut), .rdValidOut(rdValidOut),
    .rdReadyIn(rdReadyIn), .flushIn(flushIn), .levelOut(levelOut),
    .almostFullOut(almostFullOut), .overflowOut(overflowOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  int            tests = 0, fails = 0, cyc = 0, rd_count = 0;
  int            tq[$];        // write-edge timestamp of each word held
  logic [DW-1:0] exp_q[$];     // expected read data, oldest first
  bit            ovf = 0;
  bit            rdy_hist[$];  // wrReadyOut history, newest at index 0

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clkIn) begin
    if (rstNIn && rdValidOut && rdReadyIn && !flushIn) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got %0h expected no word (cycle %0d)", rdDataOut, cyc);
      end else begin
        chk("rd_data", rdDataOut, exp_q.pop_front());
        rd_count++;
      end
    end
  end

  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    bit ev, acc, rd;
    wrValidIn = wv; wrDataIn = wd; rdReadyIn = rr; flushIn = fl;
    ev  = tq.size() > 0 && tq[0] < cyc;
    acc = wv && !fl && tq.size() < DEPTH;
    rd  = ev && rr && !fl;
    @(posedge clkIn);
    cyc++;
    if (fl) begin
      tq.delete(); exp_q.delete(); ovf = 0;
    end else begin
      if (rd) void'(tq.pop_front());
      if (acc) begin tq.push_back(cyc); exp_q.push_back(wd); end
      if (wv && !acc) ovf = 1;
    end
    #1;
    chk("level", levelOut, 64'(tq.size()));
    chk("rd_valid", rdValidOut, (tq.size() > 0 && tq[0] < cyc));
    chk("wr_ready", wrReadyOut, (DEPTH - tq.size()) > SKID);
    chk("almost_full", almostFullOut, tq.size() >= AFULL);
    chk("overflow", overflowOut, ovf);
    rdy_hist.push_front(wrReadyOut);
    if (rdy_hist.size() > SKID) void'(rdy_hist.pop_back());
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_level"}, levelOut, 0);
    chk({tag, "_rd_valid"}, rdValidOut, 0);
    chk({tag, "_wr_ready"}, wrReadyOut, 0);
    chk({tag, "_afull"}, almostFullOut, 0);
    chk({tag, "_overflow"}, overflowOut, 0);
  endtask

  initial begin
    int sent, cycles, rd_base, th, n;
    bit wv, rr;
    rstNIn = 0; wrValidIn = 0; wrDataIn = '0; rdReadyIn = 0; flushIn = 0;
    for (int i = 0; i < SKID; i++) rdy_hist.push_back(1'b0);
    #2 chk_reset_outs("reset");
    repeat (2) @(posedge clkIn);
    @(negedge clkIn) rstNIn = 1;
    step(0, '0, 0, 0);
    chk("ready_after_reset", wrReadyOut, 1);

    // single word into empty FIFO
    step(1, 32'h1, 0, 0);
    step(0, '0, 0, 0);
    chk("first_valid", rdValidOut, 1);
    chk("first_data", rdDataOut, 32'h1);
    chk("first_level", levelOut, 1);
    step(0, '0, 1, 0);

    // fill to the skid threshold, then into the skid margin
    for (int i = 0; i < 28; i++) step(1, 32'h100 + i, 0, 0);
    chk("ready_low_at_28", wrReadyOut, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h200 + i, 0, 0);
    chk("full_level", levelOut, 32);
    chk("full_no_overflow", overflowOut, 0);

    // write at full with read: dropped
    step(1, 32'hDEAD, 1, 0);
    chk("drop_level", levelOut, 31);
    chk("drop_overflow", overflowOut, 1);

    // flush at level 17 with a write
    for (int i = 0; i < 14; i++) step(0, '0, 1, 0);
    chk("pre_flush_level", levelOut, 17);
    step(1, 32'hBEEF, 0, 1);
    chk("flush_level", levelOut, 0);
    chk("flush_valid", rdValidOut, 0);
    chk("flush_overflow", overflowOut, 0);
    chk("flush_ready", wrReadyOut, 1);

    // random streaming with upstream seeing ready SKID-1 cycles late
    rd_base = rd_count; sent = 0; cycles = 0;
    while (sent < 1000 && cycles < 60000) begin
      th = (sent < 334) ? 8 : (sent < 667) ? 2 : 1;
      wv = rdy_hist[SKID-1] && ($urandom_range(0, 15) < th);
      rr = $urandom_range(0, 15) < th;
      step(wv, sent, rr, 0);
      if (wv) sent++;
      cycles++;
    end
    chk("rand_all_sent", sent, 1000);
    n = 0;
    while (tq.size() > 0 && n < 200) begin step(0, '0, 1, 0); n++; end
    step(0, '0, 0, 0);
    chk("rand_words_read", rd_count - rd_base, 1000);
    chk("rand_overflow", overflowOut, 0);

    // reset mid-stream at level 10
    for (int i = 0; i < 10; i++) step(1, 32'h500 + i, 0, 0);
    chk("pre_reset_level", levelOut, 10);
    #2 rstNIn = 0;
    #1 chk_reset_outs("midreset");
    tq.delete(); exp_q.delete(); ovf = 0;
    wrValidIn = 1; wrDataIn = 32'hBAD;
    @(posedge clkIn); cyc++;
    #1 chk("reset_ignores_write", levelOut, 0);
    @(negedge clkIn) begin rstNIn = 1; wrValidIn = 0; end
    step(0, '0, 0, 0);
    step(1, 32'h600, 0, 0);
    step(0, '0, 0, 0);
    chk("post_reset_valid", rdValidOut, 1);
    chk("post_reset_data", rdDataOut, 32'h600);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    chk("post_reset_empty", levelOut, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
